// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and default sizing for the data-memory stage.
// Holds the access FSM state encoding used by data_mem_ctrl.
package mem_pkg;

  localparam int DATA_W_DFLT      = 32;
  localparam int DEPTH_DFLT       = 64;
  localparam int BASE_ADDR_DFLT   = 1024;
  localparam int WAIT_STATES_DFLT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Pipeline-side bundle of the data-memory stage: request fields in, load result and stall out.
// master = upstream pipeline, slave = data_mem_ctrl.
interface data_mem_ctrl_if #(
  parameter int DATA_W = mem_pkg::DATA_W_DFLT
);

  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic              BYTE_MODE;
  logic [DATA_W-1:0] ALU_Res;
  logic [DATA_W-1:0] Val_Rm;
  logic [3:0]        Dest;
  logic [DATA_W-1:0] pc;

  logic              WB_EN_out;
  logic              MEM_R_EN_out;
  logic [3:0]        MEM_Dest;
  logic [DATA_W-1:0] ALU_Res_out;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] DataMemory_out;
  logic              freeze;
  logic              addr_err;

  modport master (
    output WB_EN, MEM_R_EN, MEM_W_EN, BYTE_MODE, ALU_Res, Val_Rm, Dest, pc,
    input  WB_EN_out, MEM_R_EN_out, MEM_Dest, ALU_Res_out, pc_out,
           DataMemory_out, freeze, addr_err
  );

  modport slave (
    input  WB_EN, MEM_R_EN, MEM_W_EN, BYTE_MODE, ALU_Res, Val_Rm, Dest, pc,
    output WB_EN_out, MEM_R_EN_out, MEM_Dest, ALU_Res_out, pc_out,
           DataMemory_out, freeze, addr_err
  );

endinterface

// File: rtl/dmem_ram.sv
// DEPTH x DATA_W storage with per-byte write enables; read is combinational, write on clk.
// Contents are never reset.
module dmem_ram #(
  parameter int DATA_W = mem_pkg::DATA_W_DFLT,
  parameter int DEPTH  = mem_pkg::DEPTH_DFLT,
  localparam int NB    = DATA_W / 8,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage: word/byte load-store with range check; done after WAIT_STATES stall cycles.
// Stalls upstream via freeze; out-of-range or misaligned requests complete at once with no stall.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DFLT,
  parameter int DEPTH       = DEPTH_DFLT,
  parameter int BASE_ADDR   = BASE_ADDR_DFLT,
  parameter int WAIT_STATES = WAIT_STATES_DFLT
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);

  localparam int NB     = DATA_W / 8;
  localparam int SHIFT  = $clog2(NB);
  localparam int LANE_W = (NB > 1) ? SHIFT : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS      = 4'(WAIT_STATES);
  localparam bit         NO_WAIT = (WAIT_STATES == 0);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] offset, idx_full, rdata, wdata, load_byte;
  logic [LANE_W-1:0] lane;
  logic [NB-1:0]     be;
  logic              req, below, over, misalign, addr_err, ok, done, we;

  assign req      = bus.MEM_R_EN | bus.MEM_W_EN;
  assign offset   = bus.ALU_Res - DATA_W'(BASE_ADDR);
  assign idx_full = offset >> SHIFT;
  assign lane     = LANE_W'(bus.ALU_Res & DATA_W'(NB - 1));
  assign below    = bus.ALU_Res < DATA_W'(BASE_ADDR);
  assign over     = idx_full >= DATA_W'(DEPTH);
  assign misalign = ~bus.BYTE_MODE & (lane != '0);
  assign addr_err = req & (below | over | misalign);

  // Reset gates the access so nothing stalls or writes while rst is held low.
  assign ok   = req & ~addr_err & rst;
  assign done = ok & (NO_WAIT | (state == WAIT && cnt == 4'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Dropping the request mid-wait (flush) returns to IDLE without a write.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (ok && !NO_WAIT) begin
          state_nxt = WAIT;
          cnt_nxt   = WS - 4'd1;
        end
      end
      WAIT: begin
        if (!ok || done) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign we    = done & bus.MEM_W_EN;
  assign be    = bus.BYTE_MODE ? (NB'(1) << lane) : {NB{1'b1}};
  assign wdata = bus.BYTE_MODE ? {NB{bus.Val_Rm[7:0]}} : bus.Val_Rm;

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .idx   (idx_full[IDX_W-1:0]),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign load_byte = (rdata >> {lane, 3'b000}) & DATA_W'(8'hFF);

  assign bus.DataMemory_out = (done & bus.MEM_R_EN & ~bus.MEM_W_EN)
                            ? (bus.BYTE_MODE ? load_byte : rdata) : '0;
  assign bus.freeze       = ok & ~done;
  assign bus.addr_err     = addr_err;
  assign bus.WB_EN_out    = bus.WB_EN;
  assign bus.MEM_R_EN_out = bus.MEM_R_EN;
  assign bus.MEM_Dest     = bus.Dest;
  assign bus.ALU_Res_out  = bus.ALU_Res;
  assign bus.pc_out       = bus.pc;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: four instances with WAIT_STATES 0/2/3/4 share clk and rst.
// Vector table feeds a scoreboard queue; flush and mid-wait reset are hand sequences.
module tb_data_mem_ctrl;

  localparam int ND = 4;

  typedef struct {
    int          d;
    logic        r;
    logic        w;
    logic        bm;
    logic [31:0] a;
    logic [31:0] v;
    logic        err;
    int          frz;
    logic [31:0] dout;
  } vec_t;

  typedef struct {
    logic        err;
    int          frz;
    logic [31:0] dout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wb_en [ND], r_en [ND], w_en [ND], byte_m [ND];
  logic [31:0] alu [ND], val [ND], pc_in [ND];
  logic [3:0]  dest [ND];
  logic        wb_o [ND], mr_o [ND], frz [ND], aerr [ND];
  logic [3:0]  dest_o [ND];
  logic [31:0] alu_o [ND], pc_o [ND], dmo [ND];

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q [$];
  vec_t vt [$];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 4;
    data_mem_ctrl_if #(.DATA_W(32)) bus ();
    assign bus.WB_EN     = wb_en[g];
    assign bus.MEM_R_EN  = r_en[g];
    assign bus.MEM_W_EN  = w_en[g];
    assign bus.BYTE_MODE = byte_m[g];
    assign bus.ALU_Res   = alu[g];
    assign bus.Val_Rm    = val[g];
    assign bus.Dest      = dest[g];
    assign bus.pc        = pc_in[g];
    assign wb_o[g]   = bus.WB_EN_out;
    assign mr_o[g]   = bus.MEM_R_EN_out;
    assign dest_o[g] = bus.MEM_Dest;
    assign alu_o[g]  = bus.ALU_Res_out;
    assign pc_o[g]   = bus.pc_out;
    assign dmo[g]    = bus.DataMemory_out;
    assign frz[g]    = bus.freeze;
    assign aerr[g]   = bus.addr_err;
    data_mem_ctrl #(
      .DATA_W      (32),
      .DEPTH       (64),
      .BASE_ADDR   (1024),
      .WAIT_STATES (WS)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic w, input logic bm,
                       input logic [31:0] a, input logic [31:0] v);
    for (int k = 0; k < ND; k++) begin
      if (k != d) begin
        r_en[k] = 1'b0;
        w_en[k] = 1'b0;
      end
    end
    wb_en[d]  = r;
    r_en[d]   = r;
    w_en[d]   = w;
    byte_m[d] = bm;
    alu[d]    = a;
    val[d]    = v;
    dest[d]   = a[5:2];
    pc_in[d]  = a + 32'h100;
  endtask

  // Called just after a rising edge; returns just after the edge that ends the done cycle.
  task automatic access(input int d, input logic r, input logic w, input logic bm,
                        input logic [31:0] a, input logic [31:0] v, input string nm);
    int   n  = 0;
    bit   ok = 1'b0;
    exp_t e;
    drive(d, r, w, bm, a, v);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!frz[d]) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) chk({nm, "_timeout"}, 32'd1, 32'd0);
    e = exp_q.pop_front();
    chk({nm, "_freeze_cycles"}, 32'(n), 32'(e.frz));
    chk({nm, "_addr_err"}, {31'd0, aerr[d]}, {31'd0, e.err});
    chk({nm, "_dout"}, dmo[d], e.dout);
    chk({nm, "_pc_out"}, pc_o[d], a + 32'h100);
    chk({nm, "_alu_out"}, alu_o[d], a);
    chk({nm, "_dest"}, {28'd0, dest_o[d]}, {28'd0, a[5:2]});
    chk({nm, "_wb_mr"}, {30'd0, wb_o[d], mr_o[d]}, {30'd0, r, r});
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < ND; k++) begin
      wb_en[k] = 0; r_en[k] = 0; w_en[k] = 0; byte_m[k] = 0;
      alu[k] = 0; val[k] = 0; dest[k] = 0; pc_in[k] = 0;
    end

    //        d  r  w  bm  addr  data          err frz dout
    vt.push_back('{0, 0, 1, 0, 1024, 32'hDEADBEEF, 0, 0, 32'h0});
    vt.push_back('{0, 1, 0, 0, 1024, 32'h0,        0, 0, 32'hDEADBEEF});
    vt.push_back('{0, 0, 1, 0, 1024, 32'h11223344, 0, 0, 32'h0});
    vt.push_back('{0, 0, 1, 1, 1026, 32'hFFFFFFAB, 0, 0, 32'h0});
    vt.push_back('{0, 1, 0, 0, 1024, 32'h0,        0, 0, 32'h11AB3344});
    vt.push_back('{0, 1, 0, 1, 1026, 32'h0,        0, 0, 32'h000000AB});
    vt.push_back('{0, 1, 0, 1, 1027, 32'h0,        0, 0, 32'h00000011});
    vt.push_back('{0, 0, 1, 0, 1025, 32'h0BADBAD0, 1, 0, 32'h0});
    vt.push_back('{0, 1, 0, 0, 1020, 32'h0,        1, 0, 32'h0});
    vt.push_back('{0, 1, 0, 0, 1280, 32'h0,        1, 0, 32'h0});
    vt.push_back('{0, 1, 0, 0, 1024, 32'h0,        0, 0, 32'h11AB3344});
    vt.push_back('{0, 0, 1, 0, 1276, 32'hCAFEF00D, 0, 0, 32'h0});
    vt.push_back('{0, 1, 0, 0, 1276, 32'h0,        0, 0, 32'hCAFEF00D});
    vt.push_back('{0, 1, 1, 0, 1032, 32'h01020304, 0, 0, 32'h0});
    vt.push_back('{0, 1, 0, 0, 1032, 32'h0,        0, 0, 32'h01020304});
    vt.push_back('{0, 1, 0, 1, 1025, 32'h0,        0, 0, 32'h00000033});
    vt.push_back('{2, 0, 1, 0, 1028, 32'h12345678, 0, 3, 32'h0});
    vt.push_back('{2, 1, 0, 0, 1028, 32'h0,        0, 3, 32'h12345678});
    vt.push_back('{2, 1, 0, 1, 1029, 32'h0,        0, 3, 32'h00000056});
    vt.push_back('{2, 1, 0, 0, 1020, 32'h0,        1, 0, 32'h0});
    vt.push_back('{3, 0, 1, 0, 1032, 32'h99999999, 0, 4, 32'h0});
    vt.push_back('{1, 0, 1, 0, 1024, 32'h0A0B0C0D, 0, 2, 32'h0});
    vt.push_back('{1, 1, 0, 0, 1024, 32'h0,        0, 2, 32'h0A0B0C0D});
    vt.push_back('{1, 0, 1, 1, 1027, 32'h000000EE, 0, 2, 32'h0});
    vt.push_back('{1, 1, 0, 0, 1024, 32'h0,        0, 2, 32'hEE0B0C0D});

    // Reset state: a request held during reset must not stall.
    drive(1, 1'b0, 1'b1, 1'b0, 1024, 32'h5A5A5A5A);
    @(negedge clk);
    chk("rst_freeze_ws2", {31'd0, frz[1]}, 32'd0);
    w_en[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_freeze_ws4", {31'd0, frz[3]}, 32'd0);
    chk("idle_dout", dmo[0], 32'h0);
    chk("idle_addr_err", {31'd0, aerr[0]}, 32'd0);
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      exp_q.push_back('{vt[i].err, vt[i].frz, vt[i].dout});
      access(vt[i].d, vt[i].r, vt[i].w, vt[i].bm, vt[i].a, vt[i].v, $sformatf("vec%0d", i));
    end

    // Reset during the second stall cycle of a WAIT_STATES=4 store aborts it.
    drive(3, 1'b0, 1'b1, 1'b0, 1032, 32'h00000055);
    @(negedge clk);
    chk("rst_mid_frz1", {31'd0, frz[3]}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid_frz2", {31'd0, frz[3]}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_mid_in_reset", {31'd0, frz[3]}, 32'd0);
    @(posedge clk);
    #1;
    w_en[3] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back('{1'b0, 4, 32'h99999999});
    access(3, 1'b1, 1'b0, 1'b0, 1032, 32'h0, "rst_mid_reload");

    // Flush after one stall cycle on WAIT_STATES=2: no write, next access stalls fully.
    drive(1, 1'b0, 1'b1, 1'b0, 1024, 32'h00000077);
    @(negedge clk);
    chk("flush_frz1", {31'd0, frz[1]}, 32'd1);
    @(posedge clk);
    #1;
    w_en[1] = 1'b0;
    @(negedge clk);
    chk("flush_dropped", {31'd0, frz[1]}, 32'd0);
    @(posedge clk);
    #1;
    exp_q.push_back('{1'b0, 2, 32'hEE0B0C0D});
    access(1, 1'b1, 1'b0, 1'b0, 1024, 32'h0, "flush_reload");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
